// File: rtl/demux_pkg.sv
// demux_pkg: shared widths and mode encodings for the registered 1-to-8 demux
package demux_pkg;
   localparam int DW = 3;
   localparam int CH = 8;
   localparam int SW = 3;
   localparam logic MODE_ADDR = 1'b0;
   localparam logic MODE_RR = 1'b1;
endpackage

// File: rtl/demux_1_8_reg_if.sv
// demux_1_8_reg_if: producer-side handshake, channel outputs and pointer of the demux
interface demux_1_8_reg_if
   import demux_pkg::*;
#(parameter int DW = demux_pkg::DW);
   logic mode;
   logic [SW-1:0] s;
   logic [DW-1:0] d;
   logic in_valid;
   logic in_ready;
   logic [DW-1:0] y0, y1, y2, y3, y4, y5, y6, y7;
   logic [CH-1:0] y_valid;
   logic [CH-1:0] y_ready;
   logic [SW-1:0] ptr;
   modport master(output mode, s, d, in_valid, y_ready,
                  input in_ready, y0, y1, y2, y3, y4, y5, y6, y7, y_valid, ptr);
   modport slave(input mode, s, d, in_valid, y_ready,
                 output in_ready, y0, y1, y2, y3, y4, y5, y6, y7, y_valid, ptr);
endinterface

// File: rtl/demux_slot.sv
// demux_slot: one output channel, data register plus valid flag
module demux_slot #(parameter int DW = demux_pkg::DW) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic          drain,
   input  logic [DW-1:0] d,
   output logic [DW-1:0] y,
   output logic          v
);
   // a load wins over a drain in the same cycle, so the word is replaced, not lost
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y <= '0;
         v <= 1'b0;
      end else begin
         if (load) y <= d;
         v <= load | (v & ~drain);
      end
   end
endmodule

// File: rtl/demux_1_8_reg.sv
// demux_1_8_reg: registered 1-to-8 demux with addressed or round-robin targeting
module demux_1_8_reg
   import demux_pkg::*;
#(
   parameter int DW = demux_pkg::DW,
   parameter int CH = demux_pkg::CH
) (
   input logic clk,
   input logic rst_n,
   demux_1_8_reg_if.slave bus
);
   logic [SW-1:0] tgt;
   logic [SW-1:0] ptr_q;
   logic [CH-1:0] v;
   logic rdy;
   logic acc;
   logic [DW-1:0] y [CH];
   assign tgt = (bus.mode == MODE_RR) ? ptr_q : bus.s;
   assign rdy = ~v[tgt] | bus.y_ready[tgt];
   assign acc = bus.in_valid & rdy;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr_q <= '0;
      else if (acc && bus.mode == MODE_RR) ptr_q <= ptr_q + 1'b1;
   end
   for (genvar i = 0; i < CH; i++) begin : g_slot
      demux_slot #(.DW(DW)) u_slot (
         .clk(clk), .rst_n(rst_n), .load(acc && tgt == SW'(i)), .drain(bus.y_ready[i]),
         .d(bus.d), .y(y[i]), .v(v[i])
      );
   end
   assign bus.in_ready = rdy;
   assign bus.y_valid = v;
   assign bus.ptr = ptr_q;
   assign bus.y0 = y[0];
   assign bus.y1 = y[1];
   assign bus.y2 = y[2];
   assign bus.y3 = y[3];
   assign bus.y4 = y[4];
   assign bus.y5 = y[5];
   assign bus.y6 = y[6];
   assign bus.y7 = y[7];
endmodule

// File: tb/tb_demux_1_8_reg.sv
// tb_demux_1_8_reg: directed vectors, channel-array model and per-cycle compare
module tb_demux_1_8_reg;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic chk_en = 1'b0;
   int n_tests = 0;
   int n_fail = 0;
   demux_1_8_reg_if #(.DW(3)) bus();
   demux_1_8_reg u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   logic [2:0] dy [8];
   assign dy[0] = bus.y0;
   assign dy[1] = bus.y1;
   assign dy[2] = bus.y2;
   assign dy[3] = bus.y3;
   assign dy[4] = bus.y4;
   assign dy[5] = bus.y5;
   assign dy[6] = bus.y6;
   assign dy[7] = bus.y7;
   logic [2:0] m_y [8];
   logic [7:0] m_v;
   logic [2:0] m_ptr;
   int mt;
   logic ma;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) m_y[i] <= 3'd0;
         m_v <= 8'h00;
         m_ptr <= 3'd0;
      end else begin
         mt = bus.mode ? int'(m_ptr) : int'(bus.s);
         ma = bus.in_valid && (!m_v[mt] || bus.y_ready[mt]);
         for (int i = 0; i < 8; i++) begin
            if (ma && i == mt) begin
               m_y[i] <= bus.d;
               m_v[i] <= 1'b1;
            end else if (bus.y_ready[i]) m_v[i] <= 1'b0;
         end
         if (ma && bus.mode) m_ptr <= 3'((int'(m_ptr) + 1) % 8);
      end
   end
   always @(negedge clk) begin
      if (chk_en) begin
         int t;
         t = bus.mode ? int'(m_ptr) : int'(bus.s);
         chk("cyc_y_valid", 32'(bus.y_valid), 32'(m_v));
         chk("cyc_ptr", 32'(bus.ptr), 32'(m_ptr));
         chk("cyc_in_ready", 32'(bus.in_ready), 32'(!m_v[t] || bus.y_ready[t]));
         for (int i = 0; i < 8; i++) chk($sformatf("cyc_y%0d", i), 32'(dy[i]), 32'(m_y[i]));
      end
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic put(input logic m, input logic [2:0] sel, input logic [2:0] dat, input logic [7:0] yr);
      bus.mode = m;
      bus.s = sel;
      bus.d = dat;
      bus.in_valid = 1'b1;
      bus.y_ready = yr;
      tick();
      bus.in_valid = 1'b0;
   endtask
   initial begin
      bus.mode = 1'b0;
      bus.s = 3'd0;
      bus.d = 3'd0;
      bus.in_valid = 1'b0;
      bus.y_ready = 8'h00;
      tick();
      tick();
      chk("rst_y_valid", 32'(bus.y_valid), 32'h00);
      chk("rst_ptr", 32'(bus.ptr), 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      #2 rst_n = 1'b1;
      tick();
      chk_en = 1'b1;
      put(1'b0, 3'd5, 3'b110, 8'h00);
      chk("addr_y5", 32'(bus.y5), 32'b110);
      chk("addr_y_valid", 32'(bus.y_valid), 32'h20);
      chk("addr_in_ready_full", 32'(bus.in_ready), 32'd0);
      bus.d = 3'b011;
      bus.y_ready = 8'h20;
      bus.in_valid = 1'b1;
      #1 chk("bp_in_ready", 32'(bus.in_ready), 32'd1);
      tick();
      bus.in_valid = 1'b0;
      bus.y_ready = 8'h00;
      chk("dl_y5", 32'(bus.y5), 32'b011);
      chk("dl_y_valid", 32'(bus.y_valid), 32'h20);
      bus.y_ready = 8'hFF;
      tick();
      chk("drain_y_valid", 32'(bus.y_valid), 32'h00);
      for (int k = 0; k < 9; k++) begin
         chk($sformatf("rr_ptr_%0d", k), 32'(bus.ptr), 32'(k % 8));
         put(1'b1, 3'd0, (k < 8) ? 3'(k) : 3'd1, 8'hFF);
      end
      chk("rr_y7", 32'(bus.y7), 32'd7);
      chk("rr_y0", 32'(bus.y0), 32'd1);
      chk("rr_ptr_end", 32'(bus.ptr), 32'd1);
      chk("rr_y_valid", 32'(bus.y_valid), 32'h01);
      put(1'b1, 3'd0, 3'd2, 8'hFF);
      put(1'b1, 3'd0, 3'd3, 8'hFF);
      chk("ms_ptr3", 32'(bus.ptr), 32'd3);
      put(1'b0, 3'd6, 3'd5, 8'h00);
      chk("ms_y6", 32'(bus.y6), 32'd5);
      chk("ms_ptr_hold", 32'(bus.ptr), 32'd3);
      put(1'b1, 3'd0, 3'd4, 8'h00);
      chk("ms_y3", 32'(bus.y3), 32'd4);
      chk("ms_ptr4", 32'(bus.ptr), 32'd4);
      bus.y_ready = 8'hFF;
      tick();
      put(1'b0, 3'd1, 3'd1, 8'h00);
      put(1'b0, 3'd2, 3'd2, 8'h00);
      put(1'b0, 3'd4, 3'd7, 8'h02);
      chk("ind_y_valid", 32'(bus.y_valid), 32'h14);
      chk("ind_y4", 32'(bus.y4), 32'd7);
      bus.y_ready = 8'h00;
      bus.mode = 1'b0;
      bus.s = 3'd2;
      bus.d = 3'd6;
      bus.in_valid = 1'b1;
      #1 chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
      tick();
      bus.s = 3'd4;
      bus.mode = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      chk("stall_y2", 32'(bus.y2), 32'd2);
      chk("stall_ptr", 32'(bus.ptr), 32'd4);
      chk("stall_y_valid", 32'(bus.y_valid), 32'h14);
      bus.mode = 1'b0;
      bus.y_ready = 8'hFF;
      tick();
      for (int k = 0; k < 8; k++) put(1'b0, 3'(k), 3'(7 - k), 8'h00);
      chk("fill_y_valid", 32'(bus.y_valid), 32'hFF);
      chk("fill_y0", 32'(bus.y0), 32'd7);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_y_valid", 32'(bus.y_valid), 32'h00);
      chk("arst_ptr", 32'(bus.ptr), 32'd0);
      for (int i = 0; i < 8; i++) chk($sformatf("arst_y%0d", i), 32'(dy[i]), 32'd0);
      tick();
      #3 rst_n = 1'b1;
      tick();
      chk("rel_y_valid", 32'(bus.y_valid), 32'h00);
      chk("rel_in_ready", 32'(bus.in_ready), 32'd1);
      tick();
      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
